// File: rtl/rx_sync_pkg.sv
// Shared types and constants for the RX symbol-lock controller.
// State encoding, K28.5 patterns, default sizes and a counter-width helper.
package rx_sync_pkg;

  typedef enum logic [1:0] {
    LOS   = 2'b00,
    ACQ   = 2'b01,
    SYNC  = 2'b10,
    CHECK = 2'b11
  } sync_state_e;

  localparam logic [9:0] K285_RDN = 10'h0FA;
  localparam logic [9:0] K285_RDP = 10'h305;

  localparam int ERR_THRESH_DEF  = 4;
  localparam int GOOD_RUN_DEF    = 4;
  localparam int ACQ_TIMEOUT_DEF = 1024;

  localparam int ACQ_W_DEF = $clog2(ACQ_TIMEOUT_DEF);
  localparam int GR_W_DEF  = $clog2(GOOD_RUN_DEF + 1);

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_sync_err_mon.sv
// Up/down error counter with good-run decrement for the sync FSM.
// Ports: clr/load1/chk commands, err_sym/good_sym, err_cnt, thresh_hit, cnt_zero.
module rx_sync_err_mon
  import rx_sync_pkg::*;
#(
  parameter int ERR_THRESH = ERR_THRESH_DEF,
  parameter int GOOD_RUN   = GOOD_RUN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load1,
  input  logic       chk,
  input  logic       err_sym,
  input  logic       good_sym,
  output logic [3:0] err_cnt,
  output logic       thresh_hit,
  output logic       cnt_zero
);

  localparam int             GW    = cnt_w(GOOD_RUN);
  localparam logic [3:0]     THR   = 4'(ERR_THRESH);
  localparam logic [GW-1:0]  GLAST = GW'(GOOD_RUN - 1);

  logic [GW-1:0] good_cnt;
  logic          good_done;

  // Hints are ungated; the FSM qualifies them with its state.
  assign thresh_hit = err_sym & (err_cnt >= THR - 4'd1);
  assign good_done  = good_sym & (good_cnt == GLAST);
  assign cnt_zero   = good_done & (err_cnt <= 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      good_cnt <= '0;
    end else if (clr) begin
      err_cnt  <= '0;
      good_cnt <= '0;
    end else if (load1) begin
      err_cnt  <= 4'd1;
      good_cnt <= '0;
    end else if (chk & err_sym) begin
      good_cnt <= '0;
      err_cnt  <= thresh_hit ? THR : err_cnt + 4'd1;
    end else if (chk & good_done) begin
      good_cnt <= '0;
      err_cnt  <= (err_cnt == 4'd0) ? 4'd0 : err_cnt - 4'd1;
    end else if (chk & good_sym) begin
      good_cnt <= good_cnt + GW'(1);
    end
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// RX symbol-lock controller: sequences comma detector, tracks errors, gates data.
// Ports: en, sym_valid, code/disp_err, comma_lock/pulse in; det_en, det_rst,
// rx_sync, rx_data_en, sync_state, err_cnt, lol_pulse out.
// RX_SYNC_STATS_EN adds lol_count[7:0], a saturating loss-of-lock counter.
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int ERR_THRESH  = ERR_THRESH_DEF,
  parameter int GOOD_RUN    = GOOD_RUN_DEF,
  parameter int ACQ_TIMEOUT = ACQ_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sym_valid,
  input  logic       code_err,
  input  logic       disp_err,
  input  logic       comma_lock,
  input  logic       comma_pulse,
  output logic       det_en,
  output logic       det_rst,
  output logic       rx_sync,
  output logic       rx_data_en,
  output logic [1:0] sync_state,
  output logic [3:0] err_cnt,
  output logic       lol_pulse
`ifdef RX_SYNC_STATS_EN
  ,
  output logic [7:0] lol_count
`endif
);

  localparam int            TW    = cnt_w(ACQ_TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(ACQ_TIMEOUT - 1);

  sync_state_e   state, nxt;
  logic [TW-1:0] timer, timer_n;
  logic          det_rst_n, lol_n;
  logic          clr, load1, chk;
  logic          err_sym, good_sym;
  logic          thresh_hit, cnt_zero;

  assign err_sym    = sym_valid & (code_err | disp_err);
  assign good_sym   = sym_valid & ~(code_err | disp_err);
  assign sync_state = state;

  rx_sync_err_mon #(
    .ERR_THRESH (ERR_THRESH),
    .GOOD_RUN   (GOOD_RUN)
  ) u_err_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .load1      (load1),
    .chk        (chk),
    .err_sym    (err_sym),
    .good_sym   (good_sym),
    .err_cnt    (err_cnt),
    .thresh_hit (thresh_hit),
    .cnt_zero   (cnt_zero)
  );

  always_comb begin
    nxt       = state;
    timer_n   = timer;
    det_rst_n = 1'b0;
    lol_n     = 1'b0;
    clr       = 1'b0;
    load1     = 1'b0;
    chk       = 1'b0;
    if (!en) begin
      nxt     = LOS;
      clr     = 1'b1;
      timer_n = '0;
    end else begin
      unique case (state)
        LOS: begin
          nxt       = ACQ;
          det_rst_n = 1'b1;
          clr       = 1'b1;
          timer_n   = '0;
        end
        ACQ: begin
          clr = 1'b1;
          // Lock beats a timeout landing on the same symbol.
          if (comma_lock & comma_pulse) begin
            nxt     = SYNC;
            timer_n = '0;
          end else if (sym_valid) begin
            if (timer == TLAST) begin
              timer_n   = '0;
              det_rst_n = 1'b1;
            end else begin
              timer_n = timer + TW'(1);
            end
          end
        end
        SYNC: begin
          if (!comma_lock) begin
            nxt   = LOS;
            lol_n = 1'b1;
          end else if (err_sym) begin
            nxt   = CHECK;
            load1 = 1'b1;
          end
        end
        CHECK: begin
          if (!comma_lock) begin
            nxt   = LOS;
            lol_n = 1'b1;
          end else begin
            chk = 1'b1;
            if (thresh_hit) begin
              nxt   = LOS;
              lol_n = 1'b1;
            end else if (cnt_zero) begin
              nxt = SYNC;
            end
          end
        end
        default: nxt = LOS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOS;
      timer      <= '0;
      det_en     <= 1'b0;
      det_rst    <= 1'b0;
      rx_sync    <= 1'b0;
      rx_data_en <= 1'b0;
      lol_pulse  <= 1'b0;
    end else begin
      state      <= nxt;
      timer      <= timer_n;
      det_en     <= (nxt == ACQ);
      det_rst    <= det_rst_n;
      rx_sync    <= (nxt == SYNC) | (nxt == CHECK);
      rx_data_en <= rx_sync & sym_valid;
      lol_pulse  <= lol_n;
    end
  end

`ifdef RX_SYNC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lol_count <= '0;
    end else if (lol_n && lol_count != 8'hFF) begin
      lol_count <= lol_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Scoreboard bench for rx_sync_ctrl: random and scripted symbol streams
// against a behavioural lock/error model.
module tb_rx_sync_ctrl;

  localparam int ERR_THRESH  = 4;
  localparam int GOOD_RUN    = 4;
  localparam int ACQ_TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sym_valid = 1'b0;
  logic code_err = 1'b0;
  logic disp_err = 1'b0;
  logic comma_lock = 1'b0;
  logic comma_pulse = 1'b0;
  logic       det_en, det_rst, rx_sync, rx_data_en, lol_pulse;
  logic [1:0] sync_state;
  logic [3:0] err_cnt;
`ifdef RX_SYNC_STATS_EN
  logic [7:0] lol_count;
`endif

  always #5 clk = ~clk;

  rx_sync_ctrl #(
    .ERR_THRESH  (ERR_THRESH),
    .GOOD_RUN    (GOOD_RUN),
    .ACQ_TIMEOUT (ACQ_TIMEOUT)
  ) dut (
`ifdef RX_SYNC_STATS_EN
    .lol_count   (lol_count),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sym_valid   (sym_valid),
    .code_err    (code_err),
    .disp_err    (disp_err),
    .comma_lock  (comma_lock),
    .comma_pulse (comma_pulse),
    .det_en      (det_en),
    .det_rst     (det_rst),
    .rx_sync     (rx_sync),
    .rx_data_en  (rx_data_en),
    .sync_state  (sync_state),
    .err_cnt     (err_cnt),
    .lol_pulse   (lol_pulse)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       den;
    logic       drst;
    logic       sync;
    logic       dataen;
    logic [3:0] err;
    logic       lol;
    logic [7:0] lc;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   drst_seen = 0;

  // Model: link mode 0=lost 1=acquiring 2=locked 3=locked-with-errors.
  int   m_st, m_acq, m_err, m_good, m_lc;
  obs_t m_out;

  function automatic obs_t dut_obs();
    obs_t o;
    o.st     = sync_state;
    o.den    = det_en;
    o.drst   = det_rst;
    o.sync   = rx_sync;
    o.dataen = rx_data_en;
    o.err    = err_cnt;
    o.lol    = lol_pulse;
`ifdef RX_SYNC_STATS_EN
    o.lc     = lol_count;
`else
    o.lc     = 8'd0;
`endif
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_acq = 0; m_err = 0; m_good = 0; m_lc = 0;
    m_out = '0;
  endtask

  task automatic model_step();
    logic e, g, insync;
    obs_t o;
    e = sym_valid & (code_err | disp_err);
    g = sym_valid & ~(code_err | disp_err);
    insync = (m_st >= 2);
    o = '0;
    o.dataen = insync & sym_valid;
    if (!en) begin
      m_st = 0; m_err = 0; m_good = 0; m_acq = 0;
    end else begin
      case (m_st)
        0: begin
          m_st = 1; o.drst = 1'b1;
          m_acq = 0; m_err = 0; m_good = 0;
        end
        1: begin
          if (comma_lock && comma_pulse) begin
            m_st = 2; m_err = 0; m_good = 0;
          end else if (sym_valid) begin
            m_acq++;
            if (m_acq == ACQ_TIMEOUT) begin
              m_acq = 0; o.drst = 1'b1;
            end
          end
        end
        2: begin
          if (!comma_lock) begin
            m_st = 0; o.lol = 1'b1;
          end else if (e) begin
            m_st = 3; m_err = 1; m_good = 0;
          end
        end
        3: begin
          if (!comma_lock) begin
            m_st = 0; o.lol = 1'b1;
          end else if (e) begin
            m_err++; m_good = 0;
            if (m_err >= ERR_THRESH) begin
              m_err = ERR_THRESH; m_st = 0; o.lol = 1'b1;
            end
          end else if (g) begin
            m_good++;
            if (m_good == GOOD_RUN) begin
              m_good = 0;
              if (m_err > 0) m_err--;
              if (m_err == 0) m_st = 2;
            end
          end
        end
        default: m_st = 0;
      endcase
    end
    if (o.lol && m_lc < 255) m_lc++;
    o.st   = 2'(m_st);
    o.den  = (m_st == 1);
    o.sync = (m_st >= 2);
    o.err  = 4'(m_err);
`ifdef RX_SYNC_STATS_EN
    o.lc   = 8'(m_lc);
`endif
    m_out = o;
  endtask

  always @(posedge clk) begin : monitor
    obs_t e_o, a_o;
    #1;
    if (q.size() != 0) begin
      e_o = q.pop_front();
      a_o = dut_obs();
      if (a_o.drst) drst_seen++;
      checks++;
      if (a_o !== e_o) begin
        errors++;
        $display("FAIL outputs @%0t: got st=%0d den=%0b drst=%0b sync=%0b dataen=%0b err=%0d lol=%0b lc=%0d, exp st=%0d den=%0b drst=%0b sync=%0b dataen=%0b err=%0d lol=%0b lc=%0d",
                 $time, a_o.st, a_o.den, a_o.drst, a_o.sync, a_o.dataen,
                 a_o.err, a_o.lol, a_o.lc, e_o.st, e_o.den, e_o.drst,
                 e_o.sync, e_o.dataen, e_o.err, e_o.lol, e_o.lc);
      end
    end
  end

  task automatic cyc(input logic r, input logic e_, input logic sv,
                     input logic ce, input logic de, input logic cl,
                     input logic cp);
    @(negedge clk);
    rst_n = r; en = e_; sym_valid = sv; code_err = ce;
    disp_err = de; comma_lock = cl; comma_pulse = cp;
    if (!rst_n) begin
      model_reset();
      m_out = '0;
    end else begin
      model_step();
    end
    q.push_back(m_out);
  endtask

  task automatic rnd_cyc(input int err_pct, input int cp_pct,
                         input int drop_pm, input int en_pm);
    logic sv, er, ce, de, cl, cp, e_;
    sv = ($urandom_range(0, 9) != 0);
    er = ($urandom_range(0, 99) < err_pct);
    ce = er & 1'($urandom_range(0, 1));
    de = er & (~ce | 1'($urandom_range(0, 1)));
    if (!er && $urandom_range(0, 3) == 0) begin
      ce = ~sv;
    end
    cl = ($urandom_range(0, 999) >= drop_pm);
    cp = ($urandom_range(0, 99) < cp_pct);
    e_ = ($urandom_range(0, 999) >= en_pm);
    cyc(1'b1, e_, sv, ce, de, cl, cp);
  endtask

  task automatic check_zero(input string nm);
    obs_t a_o;
    a_o = dut_obs();
    checks++;
    if (a_o !== '0) begin
      errors++;
      $display("FAIL %s: got %h, expected all-zero outputs", nm, a_o);
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_at_start");
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Acquisition without lock: entry restart plus two timeouts.
    drst_seen = 0;
    repeat (2100) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (drst_seen != 3) begin
      errors++;
      $display("FAIL det_rst_count: got %0d, expected 3", drst_seen);
    end

    // Lock, then error/good patterns through CHECK.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic at increasing error rates.
    repeat (600) rnd_cyc(5, 30, 3, 2);
    repeat (600) rnd_cyc(25, 30, 3, 2);
    repeat (600) rnd_cyc(50, 30, 3, 2);

    // en drop together with an error symbol while in CHECK.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of CHECK.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_zero("async_reset_mid_check");
    model_reset();
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    repeat (400) rnd_cyc(20, 30, 3, 2);

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
